// File: rtl/lct_quality_sched_if.sv
// Candidate, shared-encoder and result signals of the LCT quality scheduler.
interface lct_quality_sched_if #(
  parameter int MXCAND = 4,
  parameter int MXIDX  = 2
);
  logic                lct_strobe;
  logic [MXCAND-1:0]   cand_acc;
  logic [MXCAND-1:0]   cand_a;
  logic [MXCAND-1:0]   cand_c;
  logic [MXCAND-1:0]   cand_a4;
  logic [MXCAND-1:0]   cand_c4;
  logic [4*MXCAND-1:0] cand_pat;
  logic [MXCAND-1:0]   cand_cpat;

  logic                qe_acc;
  logic                qe_a;
  logic                qe_c;
  logic                qe_a4;
  logic                qe_c4;
  logic                qe_cpat;
  logic [3:0]          qe_p;
  logic [3:0]          qe_q;

  logic                busy;
  logic                sort_done;
  logic                lct0_vld;
  logic [MXIDX-1:0]    lct0_idx;
  logic [3:0]          lct0_q;
  logic                lct1_vld;
  logic [MXIDX-1:0]    lct1_idx;
  logic [3:0]          lct1_q;
  logic                sched_ovf;

  modport master (
    output lct_strobe, cand_acc, cand_a, cand_c, cand_a4, cand_c4, cand_pat, cand_cpat, qe_q,
    input  qe_acc, qe_a, qe_c, qe_a4, qe_c4, qe_cpat, qe_p,
    input  busy, sort_done, lct0_vld, lct0_idx, lct0_q, lct1_vld, lct1_idx, lct1_q, sched_ovf
  );

  modport slave (
    input  lct_strobe, cand_acc, cand_a, cand_c, cand_a4, cand_c4, cand_pat, cand_cpat, qe_q,
    output qe_acc, qe_a, qe_c, qe_a4, qe_c4, qe_cpat, qe_p,
    output busy, sort_done, lct0_vld, lct0_idx, lct0_q, lct1_vld, lct1_idx, lct1_q, sched_ovf
  );
endinterface

// File: rtl/lct_quality_sched.sv
// Serialises MXCAND candidates per strobe through one shared quality encoder, keeps best two.
// Results at strobe+MXCAND+1; macro LCT_QUAL_PIPE_EN registers the encoder path (+1 cycle).
module lct_quality_sched #(
  parameter int MXCAND = 4,
  parameter int MXIDX  = 2
) (
  input  logic               clock,
  input  logic               global_reset,
  lct_quality_sched_if.slave bus
);
  localparam int CW = $clog2(MXCAND + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef struct packed {
    logic             vld;
    logic [MXIDX-1:0] idx;
    logic [3:0]       q;
  } rank_t;
  typedef struct packed {
    logic       acc;
    logic       a;
    logic       c;
    logic       a4;
    logic       c4;
    logic       cpat;
    logic [3:0] p;
  } qe_t;

  state_t              r_state;
  logic [CW-1:0]       r_idx;
  logic [MXCAND-1:0]   r_sh_acc, r_sh_a, r_sh_c, r_sh_a4, r_sh_c4, r_sh_cpat;
  logic [4*MXCAND-1:0] r_sh_pat;
  rank_t               r_best, r_second, r_lct0, r_lct1;
  logic                r_sort_done;
  logic                r_ovf;

  logic                w_accept;
  logic [MXCAND-1:0]   w_src_acc, w_src_a, w_src_c, w_src_a4, w_src_c4, w_src_cpat;
  logic [4*MXCAND-1:0] w_src_pat;
  logic [CW-1:0]       w_sel_idx;
  qe_t                 w_sel;
  qe_t                 w_qe_out;
  logic                w_ev_en;
  logic                w_ev_ac;
  logic [3:0]          w_ev_q;
  logic [MXIDX-1:0]    w_ev_idx;
  logic                w_last;
  rank_t               w_best_nxt, w_second_nxt;

  assign w_accept = bus.lct_strobe && (r_state != SCAN);

  // Slot mux; the pipelined build looks one slot ahead so the qe register shows slot k at T+1+k.
  always_comb begin
    w_src_acc  = r_sh_acc;
    w_src_a    = r_sh_a;
    w_src_c    = r_sh_c;
    w_src_a4   = r_sh_a4;
    w_src_c4   = r_sh_c4;
    w_src_cpat = r_sh_cpat;
    w_src_pat  = r_sh_pat;
    w_sel_idx  = r_idx;
`ifdef LCT_QUAL_PIPE_EN
    w_sel_idx = r_idx + CW'(1);
    if (w_accept) begin
      w_src_acc  = bus.cand_acc;
      w_src_a    = bus.cand_a;
      w_src_c    = bus.cand_c;
      w_src_a4   = bus.cand_a4;
      w_src_c4   = bus.cand_c4;
      w_src_cpat = bus.cand_cpat;
      w_src_pat  = bus.cand_pat;
      w_sel_idx  = '0;
    end
`endif
    w_sel = '0;
    for (int k = 0; k < MXCAND; k++) begin
      if (w_sel_idx == CW'(k)) begin
        w_sel.acc  = w_src_acc[k];
        w_sel.a    = w_src_a[k];
        w_sel.c    = w_src_c[k];
        w_sel.a4   = w_src_a4[k];
        w_sel.c4   = w_src_c4[k];
        w_sel.cpat = w_src_cpat[k];
        w_sel.p    = w_src_pat[4*k +: 4];
      end
    end
  end

`ifdef LCT_QUAL_PIPE_EN
  qe_t        r_qe;
  logic [3:0] r_qq;
  logic       r_ev_ac;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      r_qe    <= '0;
      r_qq    <= '0;
      r_ev_ac <= 1'b0;
    end else begin
      r_qq    <= bus.qe_q;
      r_ev_ac <= r_qe.a | r_qe.c;
      if (w_accept || (r_state == SCAN && r_idx < CW'(MXCAND - 1))) r_qe <= w_sel;
      else                                                         r_qe <= '0;
    end
  end

  // Phase p evaluates slot p-1; phase MXCAND is the drain cycle.
  assign w_ev_en  = (r_state == SCAN) && (r_idx != '0);
  assign w_ev_ac  = r_ev_ac;
  assign w_ev_q   = r_qq;
  assign w_ev_idx = MXIDX'(r_idx - CW'(1));
  assign w_last   = (r_idx == CW'(MXCAND));
  assign w_qe_out = r_qe;
`else
  assign w_ev_en  = (r_state == SCAN);
  assign w_ev_ac  = w_sel.a | w_sel.c;
  assign w_ev_q   = bus.qe_q;
  assign w_ev_idx = MXIDX'(r_idx);
  assign w_last   = (r_idx == CW'(MXCAND - 1));
  assign w_qe_out = (r_state == SCAN) ? w_sel : '0;
`endif

  // Strict compares keep the earlier slot on equal quality.
  always_comb begin
    w_best_nxt   = r_best;
    w_second_nxt = r_second;
    if (w_ev_en && w_ev_ac && (w_ev_q != 4'd0)) begin
      if (w_ev_q > r_best.q) begin
        w_second_nxt = r_best;
        w_best_nxt   = '{vld: 1'b1, idx: w_ev_idx, q: w_ev_q};
      end else if (w_ev_q > r_second.q) begin
        w_second_nxt = '{vld: 1'b1, idx: w_ev_idx, q: w_ev_q};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_sh_acc    <= '0;
      r_sh_a      <= '0;
      r_sh_c      <= '0;
      r_sh_a4     <= '0;
      r_sh_c4     <= '0;
      r_sh_cpat   <= '0;
      r_sh_pat    <= '0;
      r_best      <= '0;
      r_second    <= '0;
      r_lct0      <= '0;
      r_lct1      <= '0;
      r_sort_done <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_sort_done <= 1'b0;
      if (bus.lct_strobe && r_state == SCAN) r_ovf <= 1'b1;
      if (w_accept) begin
        r_sh_acc  <= bus.cand_acc;
        r_sh_a    <= bus.cand_a;
        r_sh_c    <= bus.cand_c;
        r_sh_a4   <= bus.cand_a4;
        r_sh_c4   <= bus.cand_c4;
        r_sh_cpat <= bus.cand_cpat;
        r_sh_pat  <= bus.cand_pat;
        r_best    <= '0;
        r_second  <= '0;
        r_idx     <= '0;
        r_state   <= SCAN;
      end else if (r_state == SCAN) begin
        r_best   <= w_best_nxt;
        r_second <= w_second_nxt;
        r_idx    <= r_idx + CW'(1);
        if (w_last) begin
          r_state     <= DONE;
          r_lct0      <= w_best_nxt;
          r_lct1      <= w_second_nxt;
          r_sort_done <= 1'b1;
        end
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.qe_acc    = w_qe_out.acc;
  assign bus.qe_a      = w_qe_out.a;
  assign bus.qe_c      = w_qe_out.c;
  assign bus.qe_a4     = w_qe_out.a4;
  assign bus.qe_c4     = w_qe_out.c4;
  assign bus.qe_cpat   = w_qe_out.cpat;
  assign bus.qe_p      = w_qe_out.p;
  assign bus.busy      = (r_state != IDLE);
  assign bus.sort_done = r_sort_done;
  assign bus.lct0_vld  = r_lct0.vld;
  assign bus.lct0_idx  = r_lct0.idx;
  assign bus.lct0_q    = r_lct0.q;
  assign bus.lct1_vld  = r_lct1.vld;
  assign bus.lct1_idx  = r_lct1.idx;
  assign bus.lct1_q    = r_lct1.q;
  assign bus.sched_ovf = r_ovf;
endmodule
